// File: rtl/vend_pkg.sv
// Shared definitions for the vending change path: coin codes, coin values and
// the change-dispenser state encoding.
package vend_pkg;

  // Coin codes as presented to the hopper solenoid driver.
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_NI   = 2'b01;
  localparam logic [1:0] COIN_DI   = 2'b10;
  localparam logic [1:0] COIN_QU   = 2'b11;

  // Coin values in cents.
  localparam int unsigned VAL_NI = 5;
  localparam int unsigned VAL_DI = 10;
  localparam int unsigned VAL_QU = 25;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StOffer,
    StGap,
    StDone
  } disp_state_e;

  // Cent value of a coin code; COIN_NONE is worth nothing.
  function automatic int unsigned coin_value(input logic [1:0] code);
    int unsigned val;
    case (code)
      COIN_NI: val = VAL_NI;
      COIN_DI: val = VAL_DI;
      COIN_QU: val = VAL_QU;
      default: val = 0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-type coin stock for the change dispenser: three down-counters loaded with
// their INIT_* values on reset or refill, one decrement per dispensed coin, and
// a force-empty for a coin type found to be jammed.
module coin_inventory
  import vend_pkg::*;
#(
  parameter int unsigned INV_W   = 6,
  parameter int unsigned INIT_QU = 10,
  parameter int unsigned INIT_DI = 10,
  parameter int unsigned INIT_NI = 20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_refill,
  input  logic       i_dec,
  input  logic       i_force_empty,
  input  logic [1:0] i_sel_type,
  output logic [2:0] o_inv_empty
);

  logic [INV_W-1:0] r_qu;
  logic [INV_W-1:0] r_di;
  logic [INV_W-1:0] r_ni;

  // Counter update: load beats force-empty beats decrement; never decrement at 0.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_refill) begin
      r_qu <= INV_W'(INIT_QU);
      r_di <= INV_W'(INIT_DI);
      r_ni <= INV_W'(INIT_NI);
    end else if (i_force_empty) begin
      if (i_sel_type == COIN_QU) r_qu <= '0;
      if (i_sel_type == COIN_DI) r_di <= '0;
      if (i_sel_type == COIN_NI) r_ni <= '0;
    end else if (i_dec) begin
      if (i_sel_type == COIN_QU && r_qu != '0) r_qu <= r_qu - INV_W'(1);
      if (i_sel_type == COIN_DI && r_di != '0) r_di <= r_di - INV_W'(1);
      if (i_sel_type == COIN_NI && r_ni != '0) r_ni <= r_ni - INV_W'(1);
    end
  end

  assign o_inv_empty = {r_qu == '0, r_di == '0, r_ni == '0};

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a cent amount out greedily (quarter, dime, nickel) one
// coin per hopper handshake, tracking coin stock and reporting unpaid cents.
// Optional build macro COIN_TIMEOUT_EN adds an ack timeout that marks a coin
// type as jammed (stock forced to zero) and retries with smaller coins.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W          = 7,
  parameter int unsigned INV_W          = 6,
  parameter int unsigned INIT_QU        = 10,
  parameter int unsigned INIT_DI        = 10,
  parameter int unsigned INIT_NI        = 20,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             coin_ack,
  input  logic             refill,
  output logic             busy,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  output logic             done,
  output logic [AMT_W-1:0] shortfall,
  output logic [2:0]       inv_empty
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  disp_state_e      r_state;
  disp_state_e      w_state_next;
  logic [AMT_W-1:0] r_remain;
  logic [AMT_W-1:0] r_shortfall;
  logic [AMT_W-1:0] w_residue;
  logic [AMT_W-1:0] w_sel_val;
  logic [1:0]       r_sel_type;
  logic [1:0]       w_sel;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             w_refill;
  logic             w_dec;
  logic             w_force;
  logic             w_to_expire;

  // Amounts that are not a multiple of 5 can never be paid in full.
  assign w_residue = amount % AMT_W'(5);
  assign w_sel_val = AMT_W'(coin_value(r_sel_type));
  assign w_refill  = refill && (r_state == StIdle);

`ifdef COIN_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] r_to_cnt;

  assign w_to_expire = (r_state == StOffer) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Ack timeout counter: runs only while a coin is offered, restarts per offer.
  always_ff @(posedge CLK) begin
    if (reset || r_state != StOffer) begin
      r_to_cnt <= '0;
    end else if (!w_to_expire) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end
`else
  assign w_to_expire = 1'b0;
`endif

  // Greedy pick: largest coin that fits the remainder and is still in stock.
  always_comb begin
    w_sel = COIN_NONE;
    if (r_remain >= AMT_W'(VAL_QU) && !inv_empty[2]) begin
      w_sel = COIN_QU;
    end else if (r_remain >= AMT_W'(VAL_DI) && !inv_empty[1]) begin
      w_sel = COIN_DI;
    end else if (r_remain >= AMT_W'(VAL_NI) && !inv_empty[0]) begin
      w_sel = COIN_NI;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, inventory strobes and state-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    w_dec        = 1'b0;
    w_force      = 1'b0;
    busy         = (r_state != StIdle);
    coin_valid   = (r_state == StOffer);
    coin_type    = (r_state == StOffer) ? r_sel_type : COIN_NONE;
    done         = (r_state == StDone);
    unique case (r_state)
      StIdle: begin
        if (start) w_state_next = StSelect;
      end
      StSelect: begin
        w_state_next = (w_sel == COIN_NONE) ? StDone : StOffer;
      end
      StOffer: begin
        if (coin_ack) begin
          w_dec        = 1'b1;
          w_state_next = (GAP_CYCLES > 0) ? StGap : StSelect;
        end else if (w_to_expire) begin
          w_force      = 1'b1;
          w_state_next = StSelect;
        end
      end
      StGap: begin
        if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) w_state_next = StSelect;
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Request datapath: remainder, latched coin choice, gap count, shortfall.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_remain    <= '0;
      r_shortfall <= '0;
      r_sel_type  <= COIN_NONE;
      r_gap_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_remain    <= amount - w_residue;
            r_shortfall <= w_residue;
          end
        end
        StSelect: begin
          r_sel_type <= w_sel;
          r_gap_cnt  <= '0;
          if (w_sel == COIN_NONE) r_shortfall <= r_shortfall + r_remain;
        end
        StOffer: begin
          if (coin_ack) r_remain <= r_remain - w_sel_val;
        end
        StGap: begin
          r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign shortfall = r_shortfall;

  coin_inventory #(
    .INV_W   (INV_W),
    .INIT_QU (INIT_QU),
    .INIT_DI (INIT_DI),
    .INIT_NI (INIT_NI)
  ) u_inv (
    .i_clk         (CLK),
    .i_reset       (reset),
    .i_refill      (w_refill),
    .i_dec         (w_dec),
    .i_force_empty (w_force),
    .i_sel_type    (r_sel_type),
    .o_inv_empty   (inv_empty)
  );

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser (default build): directed cases
// plus randomized requests against a cents-and-coin-counts reference model.
module tb_change_dispenser;

  localparam int INIT_QU = 10;
  localparam int INIT_DI = 10;
  localparam int INIT_NI = 20;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] amount = '0;
  logic       coin_ack = 1'b0;
  logic       refill = 1'b0;
  logic       busy;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       done;
  logic [6:0] shortfall;
  logic [2:0] inv_empty;

  int n_checks = 0;
  int n_errors = 0;

  // Reference inventory (coins on board).
  int m_qu = INIT_QU;
  int m_di = INIT_DI;
  int m_ni = INIT_NI;

  always #5 CLK = ~CLK;

  change_dispenser dut (
    .CLK        (CLK),
    .reset      (reset),
    .start      (start),
    .amount     (amount),
    .coin_ack   (coin_ack),
    .refill     (refill),
    .busy       (busy),
    .coin_valid (coin_valid),
    .coin_type  (coin_type),
    .done       (done),
    .shortfall  (shortfall),
    .inv_empty  (inv_empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] m_empty();
    return {m_qu == 0, m_di == 0, m_ni == 0};
  endfunction

  task automatic m_refill();
    m_qu = INIT_QU;
    m_di = INIT_DI;
    m_ni = INIT_NI;
  endtask

  task automatic m_take(input logic [1:0] code);
    case (code)
      2'b11: m_qu--;
      2'b10: m_di--;
      2'b01: m_ni--;
      default: ;
    endcase
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_qu"}, 32'(dut.u_inv.r_qu), m_qu);
    check({tag, "_di"}, 32'(dut.u_inv.r_di), m_di);
    check({tag, "_ni"}, 32'(dut.u_inv.r_ni), m_ni);
  endtask

  // One full request: model predicts the coin list and shortfall, the bench
  // acks each coin after a random delay and optionally pokes ignored inputs.
  task automatic do_req(input logic [6:0] amt, input bit rf, input int dmin, input int dmax,
                        input bit junk, output int short_exp);
    logic [1:0] exp_q[$];
    int rem, res, tq, td, tn, cyc, dly;
    bit fin;
    logic [1:0] front;

    if (rf) m_refill();
    res = int'(amt) % 5;
    rem = int'(amt) - res;
    tq = m_qu; td = m_di; tn = m_ni;
    exp_q.delete();
    forever begin
      if (rem >= 25 && tq > 0) begin exp_q.push_back(2'b11); rem -= 25; tq--; end
      else if (rem >= 10 && td > 0) begin exp_q.push_back(2'b10); rem -= 10; td--; end
      else if (rem >= 5 && tn > 0) begin exp_q.push_back(2'b01); rem -= 5; tn--; end
      else break;
    end
    short_exp = res + rem;

    @(negedge CLK);
    start = 1'b1; amount = amt; refill = rf;
    @(negedge CLK);
    start = 1'b0; refill = 1'b0; amount = 7'($urandom);
    check("lat_busy", busy, 1);
    check("lat_valid0", coin_valid, 0);
    check("lat_done0", done, 0);
    @(negedge CLK);
    check("lat_valid", coin_valid, exp_q.size() > 0);
    check("lat_done", done, exp_q.size() == 0);

    fin = 1'b0;
    cyc = 0;
    while (!fin && cyc < 400) begin
      check("inv_empty", inv_empty, m_empty());
      if (done) begin
        check("shortfall", shortfall, short_exp);
        check("coins_left", exp_q.size(), 0);
        fin = 1'b1;
      end else if (coin_valid) begin
        front = (exp_q.size() > 0) ? exp_q[0] : 2'b00;
        check("coin_type", coin_type, front);
        dly = $urandom_range(dmax, dmin);
        for (int k = 0; k < dly; k++) begin
          start = junk && ($urandom_range(0, 2) == 0);
          amount = 7'($urandom);
          @(negedge CLK);
          cyc++;
          check("hold_valid", coin_valid, 1);
          check("hold_type", coin_type, front);
        end
        start = 1'b0;
        coin_ack = 1'b1;
        @(negedge CLK);
        coin_ack = 1'b0;
        cyc++;
        m_take(front);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check("ack_clear", coin_valid, 0);
      end else begin
        if (junk) begin
          coin_ack = 1'($urandom_range(0, 1));
          start = 1'($urandom_range(0, 1));
          refill = 1'($urandom_range(0, 1));
          amount = 7'($urandom);
        end
        @(negedge CLK);
        cyc++;
        coin_ack = 1'b0; start = 1'b0; refill = 1'b0;
      end
    end
    check("req_finished", fin, 1);
    @(negedge CLK);
    check("idle_busy", busy, 0);
    check("done_pulse", done, 0);
    check("short_held", shortfall, short_exp);
    check_counts("inv");
  endtask

  initial begin : main
    int sh;
    int cyc;

    // Reset state.
    repeat (3) @(negedge CLK);
    check("rst_busy", busy, 0);
    check("rst_valid", coin_valid, 0);
    check("rst_type", coin_type, 0);
    check("rst_done", done, 0);
    check("rst_short", shortfall, 0);
    check("rst_empty", inv_empty, 3'b000);
    check_counts("rst_inv");
    reset = 1'b0;
    @(negedge CLK);
    check("post_rst_busy", busy, 0);

    // 40c, ack one cycle after each coin: QU, DI, NI.
    do_req(7'd40, 1'b0, 1, 1, 1'b0, sh);
    check("t40_short", shortfall, 0);
    check("t40_qu", 32'(dut.u_inv.r_qu), 9);
    check("t40_di", 32'(dut.u_inv.r_di), 9);
    check("t40_ni", 32'(dut.u_inv.r_ni), 19);

    // Zero amount: straight to done.
    do_req(7'd0, 1'b0, 0, 0, 1'b0, sh);
    check("t0_short", shortfall, 0);

    // 40c with slow ack, start while busy, reset during the second offer.
    @(negedge CLK);
    start = 1'b1; amount = 7'd40;
    @(negedge CLK);
    start = 1'b0;
    cyc = 0;
    while (!coin_valid && cyc < 20) begin @(negedge CLK); cyc++; end
    check("slow_first_valid", coin_valid, 1);
    check("slow_first_type", coin_type, 3);
    for (int k = 0; k < 5; k++) begin
      start = 1'b1; amount = 7'd5;
      @(negedge CLK);
      check("slow_hold_type", coin_type, 3);
      check("slow_hold_valid", coin_valid, 1);
    end
    start = 1'b0;
    coin_ack = 1'b1;
    @(negedge CLK);
    coin_ack = 1'b0;
    cyc = 0;
    while (!coin_valid && cyc < 20) begin @(negedge CLK); cyc++; end
    check("slow_second_type", coin_type, 2);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    m_refill();
    check("abort_valid", coin_valid, 0);
    check("abort_busy", busy, 0);
    check_counts("abort_inv");
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("abort_no_done", done, 0);
      check("abort_idle", busy, 0);
    end

    // Drain quarters, then dimes, then nickels down to one.
    do_req(7'd125, 1'b1, 0, 2, 1'b1, sh);
    do_req(7'd125, 1'b0, 0, 2, 1'b1, sh);
    check("drain_qu_empty", inv_empty[2], 1);
    do_req(7'd25, 1'b0, 0, 2, 1'b1, sh);
    check("noqu25_short", shortfall, 0);
    do_req(7'd80, 1'b0, 0, 2, 1'b1, sh);
    do_req(7'd90, 1'b0, 0, 2, 1'b1, sh);
    do_req(7'd15, 1'b0, 0, 2, 1'b1, sh);
    check("last_ni_short", shortfall, 10);
    check("all_empty", inv_empty, 3'b111);

    // Refill alone in IDLE.
    @(negedge CLK);
    refill = 1'b1;
    @(negedge CLK);
    refill = 1'b0;
    m_refill();
    check("refill_empty", inv_empty, 3'b000);
    check_counts("refill_inv");

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      do_req(7'($urandom_range(0, 127)), ($urandom_range(0, 3) == 0), 0, 3, 1'b1, sh);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Pays out change from the vending FSM as physical coins, one coin per handshake with the coin-release mechanism.
- Takes a change amount in cents. Dispenses greedily (quarter > dime > nickel) and tracks the on-board inventory of each coin type.
- Reports any amount that could not be paid.
- Sits between the vending FSM's change output and the coin hopper solenoid driver.

Parameters:
- AMT_W, 7, width of cent amounts (0..127).
- INV_W, 6, width of each coin inventory counter.
- INIT_QU, 10, quarter count after reset/refill.
- INIT_DI, 10, dime count after reset/refill.
- INIT_NI, 20, nickel count after reset/refill.
- GAP_CYCLES, 2, idle cycles forced between consecutive coins (0 allowed).
- TIMEOUT_CYCLES, 8, ack timeout; used only with COIN_TIMEOUT_EN.

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- amount  input  AMT_W  change in cents; must be a multiple of 5.
- coin_ack  input  1  hopper has released the offered coin.
- refill  input  1  restore all inventories to INIT_*; honoured only in IDLE.
- busy  output  1  high in every state except IDLE.
- coin_valid  output  1  a coin is being offered.
- coin_type  output  2  00 none, 01 nickel, 10 dime, 11 quarter.
- done  output  1  one-cycle pulse at end of request.
- shortfall  output  AMT_W  cents not paid; valid with done, held until next accepted start.
- inv_empty  output  3  {qu,di,ni} inventory == 0.

Behaviour:
- Interface: one clock, CLK. Reset is synchronous and active-high.
- Reset values:
  - State IDLE.
  - busy=0, coin_valid=0, coin_type=00, done=0, shortfall=0.
  - Remaining amount = 0.
  - Inventories = INIT_*; inv_empty follows.
- IDLE:
  - refill=1: inventories := INIT_*.
  - start=1: remain := amount with its low bits floored to a multiple of 5; the residue is added to shortfall. Go to SELECT.
  - refill and start in the same cycle: both take effect; the request sees the refilled inventory.
- SELECT (one cycle):
  - Choose the largest coin with value <= remain and inventory > 0, then go to OFFER.
  - remain==0 or no usable coin: go to DONE.
- OFFER:
  - coin_valid=1 and coin_type stable until coin_ack.
  - On coin_ack: remain -= value, that inventory -= 1, coin_valid/coin_type clear at the next edge.
  - Then go to GAP (GAP_CYCLES>0), else SELECT.
- GAP: count GAP_CYCLES cycles, then go to SELECT.
- DONE: done=1 for one cycle, shortfall := remain (plus any floor residue), then IDLE.
- Latency: coin_valid rises at the 2nd edge after start is sampled. With amount=0, done rises at the 2nd edge after start.
- Ignored inputs:
  - start while busy.
  - coin_ack while coin_valid=0.
  - refill while busy.
- Arithmetic: remain never underflows, because selection guarantees value <= remain. Inventory decrement never occurs at 0.
- Reset mid-request: abort at the next edge. coin_valid=0 and busy=0; no done pulse.

Optional Feature:
- Macro: COIN_TIMEOUT_EN.
- Defined:
  - OFFER counts cycles.
  - If coin_ack is absent for TIMEOUT_CYCLES cycles, the coin is treated as jammed: coin_valid drops, that type's inventory is forced to 0 (inv_empty bit set), remain is unchanged, and the FSM returns to SELECT to try smaller coins.
  - coin_ack arriving in the timeout cycle itself counts as success.
- Undefined: OFFER waits indefinitely; no timeout counter is synthesised.

Decomposition:
- Package vend_pkg:
  - Coin code constants (COIN_NONE/NI/DI/QU).
  - Coin values 5/10/25.
  - Dispenser state encoding.
- Sub-module coin_inventory:
  - Three INV_W counters.
  - Per-type decrement and force-empty.
  - Refill/reset load of INIT_*.
  - inv_empty flags.

Test Plan:
- After reset, amount=40, coin_ack asserted 1 cycle after each coin_valid -> coins QU, DI, NI in order; done; shortfall=0; inventories 9/9/19.
- amount=0 -> done at the 2nd edge after start; coin_valid never high; shortfall=0.
- INIT_QU=0, amount=25 -> DI, DI, NI; shortfall=0; inv_empty[2]=1 throughout.
- INIT_QU=0, INIT_DI=0, INIT_NI=1, amount=15 -> one NI, then done with shortfall=10.
- amount=40, coin_ack delayed 5 cycles:
  - coin_type stays 11 the whole time.
  - start pulsed while busy is ignored.
  - reset during the second OFFER -> next edge coin_valid=0, busy=0, inventories=INIT_*.
- COIN_TIMEOUT_EN, TIMEOUT_CYCLES=8, amount=25, QU never acked -> after 8 cycles QU inventory=0, inv_empty[2]=1; then DI, DI, NI acked; shortfall=0.
